// File: rtl/dra_wrreq_arbiter.sv
// Round-robin burst arbiter draining per-PE writeReq FIFOs into the
// shared packet-RAM write port, one beat per cycle with a one-cycle write latency.
module dra_wrreq_arbiter #(
    parameter int NUM_PE    = 3,
    parameter int MAX_BURST = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NUM_PE-1:0]     i_empty_writeReq,
    input  logic [NUM_PE*528-1:0] i_dout_writeReq,
    output logic [NUM_PE-1:0]     o_rden_writeReq,
    input  logic                  i_hold,
    output logic                  o_wren_pktRAM,
    output logic [15:0]           o_addr_pktRAM,
    output logic [511:0]          o_din_pktRAM,
    output logic [NUM_PE-1:0]     o_grant,
    output logic [31:0]           d_cnt_write_32b
);

    localparam int         IW   = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int         BW   = 528;
    localparam logic [3:0] MAXB = 4'(MAX_BURST);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] last_q, last_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [IW-1:0] win, rd_idx;
    logic          found, rd, rd_ok;
    logic [BW-1:0] head;

    logic          wren_q;
    logic [15:0]   addr_q;
    logic [511:0]  din_q;
    logic [31:0]   wr_cnt_q;

    // First non-empty PE after the last-served one, wrapping modulo NUM_PE.
    always_comb begin
        int            idx;
        logic [IW-1:0] cand;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        cand  = '0;
        for (int k = 1; k <= NUM_PE; k++) begin
            idx = int'(last_q) + k;
            if (idx >= NUM_PE) idx = idx - NUM_PE;
            cand = IW'(idx);
            if (!found && !i_empty_writeReq[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        rd      = 1'b0;
        rd_idx  = owner_q;
        unique case (state_q)
            S_IDLE: begin
                if (!i_hold && found) begin
                    rd      = 1'b1;
                    rd_idx  = win;
                    owner_d = win;
                    cnt_d   = 4'd1;
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                // Exit costs one bubble cycle even if others are waiting.
                if (i_empty_writeReq[owner_q] || cnt_q >= MAXB) begin
                    last_d  = owner_q;
                    state_d = S_IDLE;
                end else if (!i_hold) begin
                    rd    = 1'b1;
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rd_ok = rd & i_rst_n;
    assign head  = i_dout_writeReq[int'(rd_idx)*BW +: BW];

    assign o_rden_writeReq = rd_ok ? (NUM_PE'(1) << rd_idx) : '0;
    assign o_grant         = (state_q == S_BURST) ? (NUM_PE'(1) << owner_q) : '0;
    assign o_wren_pktRAM   = wren_q;
    assign o_addr_pktRAM   = addr_q;
    assign o_din_pktRAM    = din_q;
    assign d_cnt_write_32b = wr_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            last_q  <= IW'(NUM_PE - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wren_q   <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            wr_cnt_q <= '0;
        end else begin
            wren_q <= rd;
            if (rd) begin
                addr_q   <= head[527:512];
                din_q    <= head[511:0];
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_dra_wrreq_arbiter.sv
// Directed bench for dra_wrreq_arbiter with FWFT FIFO models per PE.
module tb_dra_wrreq_arbiter;

    localparam int NPE = 3;

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic [NPE-1:0]   i_empty_writeReq;
    logic [NPE*528-1:0] i_dout_writeReq;
    logic [NPE-1:0]   o_rden_writeReq;
    logic             i_hold = 1'b0;
    logic             o_wren_pktRAM;
    logic [15:0]      o_addr_pktRAM;
    logic [511:0]     o_din_pktRAM;
    logic [NPE-1:0]   o_grant;
    logic [31:0]      d_cnt_write_32b;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit log_on  = 1'b0;

    logic [527:0] fq [NPE][$];
    logic [15:0]  log_addr [$];
    int           log_cyc  [$];

    dra_wrreq_arbiter #(.NUM_PE(3), .MAX_BURST(4)) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_empty_writeReq (i_empty_writeReq),
        .i_dout_writeReq  (i_dout_writeReq),
        .o_rden_writeReq  (o_rden_writeReq),
        .i_hold           (i_hold),
        .o_wren_pktRAM    (o_wren_pktRAM),
        .o_addr_pktRAM    (o_addr_pktRAM),
        .o_din_pktRAM     (o_din_pktRAM),
        .o_grant          (o_grant),
        .d_cnt_write_32b  (d_cnt_write_32b)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < NPE; i++) begin
            i_empty_writeReq[i] = (fq[i].size() == 0);
            i_dout_writeReq[i*528 +: 528] = (fq[i].size() != 0) ? fq[i][0] : '0;
        end
    endtask

    task automatic push(input int pe, input logic [15:0] a, input int n);
        logic [15:0] aa;
        for (int j = 0; j < n; j++) begin
            aa = a + 16'(j);
            fq[pe].push_back({aa, {32{aa}}});
        end
        refresh();
    endtask

    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        i_hold  = 1'b0;
        for (int i = 0; i < NPE; i++) fq[i].delete();
        refresh();
        tick();
        i_rst_n = 1'b1;
        tick();
    endtask

    always @(posedge i_clk) begin
        logic [NPE-1:0] r;
        logic [527:0]   junk;
        r = o_rden_writeReq;
        cyc <= cyc + 1;
        #1;
        for (int i = 0; i < NPE; i++)
            if (r[i] && fq[i].size() > 0) junk = fq[i].pop_front();
        refresh();
    end

    always @(negedge i_clk) begin
        if (log_on && o_wren_pktRAM) begin
            log_addr.push_back(o_addr_pktRAM);
            log_cyc.push_back(cyc);
        end
    end

    initial begin
        logic [15:0] ea;
        int          bnd;
        refresh();
        // reset state with PE1 holding two beats
        repeat (2) tick();
        push(1, 16'h0010, 2);
        #1;
        check("rst_rden",  64'(o_rden_writeReq), 64'h0);
        check("rst_wren",  64'(o_wren_pktRAM), 64'h0);
        check("rst_grant", 64'(o_grant), 64'h0);
        check("rst_addr",  64'(o_addr_pktRAM), 64'h0);
        check("rst_din",   o_din_pktRAM[63:0], 64'h0);
        check("rst_cnt",   64'(d_cnt_write_32b), 64'h0);
        i_rst_n = 1'b1;
        #1;
        check("t1_rden0",  64'(o_rden_writeReq), 64'h2);
        check("t1_grant0", 64'(o_grant), 64'h0);
        tick();
        check("t1_wren1",  64'(o_wren_pktRAM), 64'h1);
        check("t1_addr1",  64'(o_addr_pktRAM), 64'h0010);
        check("t1_dinlo",  o_din_pktRAM[63:0], 64'h0010_0010_0010_0010);
        check("t1_dinhi",  o_din_pktRAM[511:448], 64'h0010_0010_0010_0010);
        check("t1_grant1", 64'(o_grant), 64'h2);
        check("t1_rden1",  64'(o_rden_writeReq), 64'h2);
        tick();
        check("t1_wren2",  64'(o_wren_pktRAM), 64'h1);
        check("t1_addr2",  64'(o_addr_pktRAM), 64'h0011);
        check("t1_rden2",  64'(o_rden_writeReq), 64'h0);
        tick();
        check("t1_wren3",  64'(o_wren_pktRAM), 64'h0);
        check("t1_grant3", 64'(o_grant), 64'h0);
        check("t1_cnt",    64'(d_cnt_write_32b), 64'd2);
        check("t1_hold",   64'(o_addr_pktRAM), 64'h0011);

        // all PEs full: round robin with bubbles
        do_reset();
        log_addr.delete();
        log_cyc.delete();
        log_on = 1'b1;
        for (int p = 0; p < NPE; p++) push(p, 16'(16'h0100 * (p + 1)), 6);
        for (int k = 0; k < 80 && log_addr.size() < 18; k++) tick();
        tick();
        log_on = 1'b0;
        check("t2_nbeats", 64'(log_addr.size()), 64'd18);
        check("t2_cnt", 64'(d_cnt_write_32b), 64'd18);
        for (int k = 0; k < 18 && k < log_addr.size(); k++) begin
            if (k < 12) ea = 16'(16'h0100 * (k / 4 + 1) + k % 4);
            else        ea = 16'(16'h0100 * ((k - 12) / 2 + 1) + 4 + k % 2);
            check($sformatf("t2_addr%0d", k), 64'(log_addr[k]), 64'(ea));
            if (k > 0) begin
                bnd = (k == 4 || k == 8 || k == 12 || k == 14 || k == 16) ? 2 : 1;
                check($sformatf("t2_gap%0d", k),
                      64'(log_cyc[k] - log_cyc[k-1]), 64'(bnd));
            end
        end

        // hold for three cycles after beat 2 of a PE0 burst
        do_reset();
        push(0, 16'h0200, 4);
        #1 check("t3_rden0", 64'(o_rden_writeReq), 64'h1);
        tick();
        check("t3_addr1", 64'(o_addr_pktRAM), 64'h0200);
        tick();
        check("t3_addr2", 64'(o_addr_pktRAM), 64'h0201);
        i_hold = 1'b1;
        #1 check("t3_hrden", 64'(o_rden_writeReq), 64'h0);
        for (int h = 0; h < 3; h++) begin
            tick();
            check($sformatf("t3_hwren%0d", h), 64'(o_wren_pktRAM), 64'h0);
            check($sformatf("t3_hgrant%0d", h), 64'(o_grant), 64'h1);
            check($sformatf("t3_hrden%0d", h), 64'(o_rden_writeReq), 64'h0);
        end
        i_hold = 1'b0;
        #1 check("t3_rrden", 64'(o_rden_writeReq), 64'h1);
        tick();
        check("t3_wren3", 64'(o_wren_pktRAM), 64'h1);
        check("t3_addr3", 64'(o_addr_pktRAM), 64'h0202);
        tick();
        check("t3_addr4", 64'(o_addr_pktRAM), 64'h0203);
        check("t3_rden4", 64'(o_rden_writeReq), 64'h0);
        tick();
        check("t3_grantx", 64'(o_grant), 64'h0);

        // last served PE2, then PE2 and PE0 request: PE0 wins
        do_reset();
        push(2, 16'h0300, 1);
        repeat (3) tick();
        push(2, 16'h0310, 1);
        push(0, 16'h0320, 1);
        #1 check("t4_rden", 64'(o_rden_writeReq), 64'h1);
        tick();
        check("t4_grant", 64'(o_grant), 64'h1);
        check("t4_addr", 64'(o_addr_pktRAM), 64'h0320);

        // reset mid-burst
        do_reset();
        push(1, 16'h0400, 4);
        #1 check("t5_rden0", 64'(o_rden_writeReq), 64'h2);
        tick();
        check("t5_rden1", 64'(o_rden_writeReq), 64'h2);
        push(0, 16'h0410, 1);
        i_rst_n = 1'b0;
        #1;
        check("t5_rrden", 64'(o_rden_writeReq), 64'h0);
        check("t5_rgrant", 64'(o_grant), 64'h0);
        check("t5_rcnt", 64'(d_cnt_write_32b), 64'h0);
        tick();
        check("t5_wren", 64'(o_wren_pktRAM), 64'h0);
        check("t5_grant", 64'(o_grant), 64'h0);
        i_rst_n = 1'b1;
        #1 check("t5_restart", 64'(o_rden_writeReq), 64'h1);

        // counter wrap
        do_reset();
        force dut.wr_cnt_q = 32'hFFFF_FFFF;
        #1 release dut.wr_cnt_q;
        #1 check("t6_pre", 64'(d_cnt_write_32b), 64'hFFFF_FFFF);
        push(2, 16'h0500, 1);
        tick();
        check("t6_wren", 64'(o_wren_pktRAM), 64'h1);
        check("t6_wrap", 64'(d_cnt_write_32b), 64'h0);
        tick();
        check("t6_post", 64'(d_cnt_write_32b), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
